// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access FSM states, wait-counter
// width and datapath widths.
package mem_pkg;

  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CntW     = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StAbort = 2'd2
  } mem_state_e;

  // Data memory is word addressed on the bus; byte offset bits are dropped.
  function automatic logic [AddrW-1:0] word_align(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and holds the
// data fields; otherwise the register loads when enabled.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                bubble_i,
  input  logic                wreg_i,
  input  logic                m2reg_i,
  input  logic [DataW-1:0]    mo_i,
  input  logic [DataW-1:0]    alu_i,
  input  logic [RegAddrW-1:0] rn_i,
  output logic                wreg_o,
  output logic                m2reg_o,
  output logic [DataW-1:0]    mo_o,
  output logic [DataW-1:0]    alu_o,
  output logic [RegAddrW-1:0] rn_o
);

  logic                wreg_d, wreg_q;
  logic                m2reg_d, m2reg_q;
  logic [DataW-1:0]    mo_d, mo_q;
  logic [DataW-1:0]    alu_d, alu_q;
  logic [RegAddrW-1:0] rn_d, rn_q;

  // Next-state: bubble wins over enable so a stalled instruction never writes back.
  always_comb begin
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    mo_d    = mo_q;
    alu_d   = alu_q;
    rn_d    = rn_q;
    if (bubble_i) begin
      wreg_d  = 1'b0;
      m2reg_d = 1'b0;
    end else if (en_i) begin
      wreg_d  = wreg_i;
      m2reg_d = m2reg_i;
      mo_d    = mo_i;
      alu_d   = alu_i;
      rn_d    = rn_i;
    end
  end

  // Register state with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      mo_q    <= '0;
      alu_q   <= '0;
      rn_q    <= '0;
    end else begin
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      mo_q    <= mo_d;
      alu_q   <= alu_d;
      rn_q    <= rn_d;
    end
  end

  assign wreg_o  = wreg_q;
  assign m2reg_o = m2reg_q;
  assign mo_o    = mo_q;
  assign alu_o   = alu_q;
  assign rn_o    = rn_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake with wait-state timeout, branch
// resolution outputs, sticky error flags and the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, a misaligned
// access is dropped (no bus request, no stall), flagged in misalign_err and
// retired as a bubble. When undefined the address is word aligned and
// misalign_err is tied low.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mwreg,
  input  logic                mm2reg,
  input  logic                mwmem,
  input  logic [DataW-1:0]    maluout,
  input  logic [DataW-1:0]    mdata_b,
  input  logic [RegAddrW-1:0] mrdrt,
  input  logic                mbranch,
  input  logic                mzero,
  input  logic [AddrW-1:0]    mpc,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [AddrW-1:0]    dmem_addr,
  output logic [DataW-1:0]    dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DataW-1:0]    dmem_rdata,
  output logic                mem_stall,
  output logic                pcsrc,
  output logic [AddrW-1:0]    bpc,
  output logic                wwreg,
  output logic                wm2reg,
  output logic [DataW-1:0]    wmo,
  output logic [DataW-1:0]    walu,
  output logic [RegAddrW-1:0] wrn,
  output logic                bus_err,
  output logic                misalign_err
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  mem_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            bus_err_d, bus_err_q;

  logic access;
  logic misalign;
  logic eff_access;
  logic in_abort;
  logic ack_vld;
  logic wb_en;
  logic wb_bubble;

  assign access   = mm2reg | mwmem;
  assign in_abort = (state_q == StAbort);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (maluout[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A trapped misaligned access never reaches the bus.
  assign eff_access = access & ~misalign;

  // Branch resolution is purely combinational.
  assign pcsrc = mbranch & mzero;
  assign bpc   = mpc;

  // Bus outputs follow the held EXE/MEM inputs, so they stay stable while stalled.
  assign dmem_req   = eff_access & ~in_abort;
  assign dmem_we    = mwmem;
  assign dmem_addr  = word_align(maluout);
  assign dmem_wdata = mdata_b;

  // An ack without an outstanding request is meaningless.
  assign ack_vld = dmem_ack & dmem_req;

  assign mem_stall = eff_access & ~dmem_ack & ~in_abort;

  // Next-state logic for the access FSM, wait counter and bus-error flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (eff_access && !ack_vld) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (!eff_access || ack_vld) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = StAbort;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAbort: begin
        // One cycle to let the aborted instruction drain as a bubble.
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and bus-error state with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_err_d, misalign_err_q;

  // Sticky misalignment flag; only reset clears it.
  always_comb begin
    misalign_err_d = misalign_err_q;
    if (misalign && !in_abort) begin
      misalign_err_d = 1'b1;
    end
  end

  // Misalignment flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  assign misalign_err = 1'b0;
`endif

  // Stalled, aborted and trapped instructions all retire as bubbles.
  assign wb_bubble = mem_stall | in_abort | misalign;
  assign wb_en     = ~wb_bubble;

  mem_wb_reg u_mem_wb_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (wb_en),
    .bubble_i (wb_bubble),
    .wreg_i   (mwreg),
    .m2reg_i  (mm2reg),
    .mo_i     (dmem_rdata),
    .alu_i    (maluout),
    .rn_i     (mrdrt),
    .wreg_o   (wwreg),
    .m2reg_o  (wm2reg),
    .mo_o     (wmo),
    .alu_o    (walu),
    .rn_o     (wrn)
  );

endmodule
